// File: rtl/mult_seq_param.sv
// Sequential Booth multiplier with start/busy/done handshake; product held in hi_out/lo_out.
// Define MULT_RADIX4_EN to use radix-4 Booth steps (WIDTH/2+1 iterations instead of WIDTH+1).
module mult_seq_param #(
    parameter int WIDTH = 32  // must be even and >= 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

`ifdef MULT_RADIX4_EN
    // Upper field carries two guard bits so that adding +/-2M never wraps.
    localparam int EW   = WIDTH + 2;
    localparam int UW   = WIDTH + 4;
    localparam int ITER = WIDTH / 2 + 1;
`else
    localparam int EW   = WIDTH + 1;
    localparam int UW   = EW;
    localparam int ITER = WIDTH + 1;
`endif
    localparam int AW = UW + EW + 1;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_next;
    logic [UW-1:0]   m_pos;
    logic [UW-1:0]   m_neg;
    logic [UW-1:0]   upper;
    logic [UW-1:0]   sum;
    logic [CW-1:0]   count;
    logic            sign_a;
    logic            sign_b;
    logic [UW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;

    assign sign_a = is_signed & multiplicand[WIDTH-1];
    assign sign_b = is_signed & multiplier[WIDTH-1];
    assign a_ext  = {{(UW - WIDTH){sign_a}}, multiplicand};
    assign b_ext  = {{(EW - WIDTH){sign_b}}, multiplier};
    assign upper  = acc[AW-1 -: UW];

`ifdef MULT_RADIX4_EN
    logic [UW-1:0] addend;

    always_comb begin
        addend = '0;
        case (acc[2:0])
            3'b001, 3'b010: addend = m_pos;
            3'b011:         addend = {m_pos[UW-2:0], 1'b0};
            3'b100:         addend = {m_neg[UW-2:0], 1'b0};
            3'b101, 3'b110: addend = m_neg;
            default:        addend = '0;
        endcase
        sum      = upper + addend;
        acc_next = {{2{sum[UW-1]}}, sum, acc[EW:2]};
    end
`else
    always_comb begin
        sum = upper;
        case (acc[1:0])
            2'b10:   sum = upper + m_neg;
            2'b01:   sum = upper + m_pos;
            default: sum = upper;
        endcase
        acc_next = {sum[UW-1], sum, acc[EW:1]};
    end
`endif

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            m_pos  <= '0;
            m_neg  <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= {{UW{1'b0}}, b_ext, 1'b0};
                        m_pos <= a_ext;
                        m_neg <= '0 - a_ext;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(ITER - 1)) begin
                        // Result is taken from the final step so hi/lo update atomically with done.
                        {hi_out, lo_out} <= acc_next[2*WIDTH:1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
